// File: rtl/eight_bit_down_counter_pkg.sv
// Shared types and defaults for the reaction-game counters.
package eight_bit_down_counter_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_PRESCALE = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  // Prescaler counter width; a divide-by-1 still keeps a 1-bit register.
  function automatic int prescale_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/eight_bit_down_counter_if.sv
// Control/status bundle between the game controller and the down counter.
interface eight_bit_down_counter_if
  import eight_bit_down_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic [WIDTH-1:0] count;
  logic             running;
  logic             expired;
  logic             done;

  modport master (
    output load, load_value, enable,
    input  count, running, expired, done
  );

  modport slave (
    input  load, load_value, enable,
    output count, running, expired, done
  );

endinterface

// File: rtl/eight_bit_down_counter_tick_prescaler.sv
// Free-running divide-by-PRESCALE tick generator; freezes while enable is low.
module tick_prescaler
  import eight_bit_down_counter_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] count_reg;
  logic [PW-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    if (clear) begin
      count_next = '0;
    end else if (enable) begin
      count_next = (count_reg == LAST) ? '0 : count_reg + PW'(1);
    end
  end

  // With PRESCALE=1 the register is stuck at 0, so tick follows enable.
  assign tick = enable && (count_reg == LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/eight_bit_down_counter.sv
// Loadable down counter with prescaler; flags expiry and pulses done on entry to EXPIRED.
module eight_bit_down_counter
  import eight_bit_down_counter_pkg::*;
#(
  parameter int WIDTH    = DEFAULT_WIDTH,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input logic                    clock,
  input logic                    reset,
  eight_bit_down_counter_if.slave bus
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             done_reg;
  logic             done_next;
  logic             pre_enable;
  logic             tick;

  assign pre_enable = bus.enable && (state_reg == RUN);

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clock  (clock),
    .reset  (reset),
    .clear  (bus.load),
    .enable (pre_enable),
    .tick   (tick)
  );

  // Load outranks everything, so a tick coinciding with a load is dropped.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    done_next  = 1'b0;
    if (bus.load) begin
      count_next = bus.load_value;
      if (bus.load_value == '0) begin
        state_next = EXPIRED;
        done_next  = 1'b1;
      end else begin
        state_next = RUN;
      end
    end else begin
      case (state_reg)
        IDLE: begin
        end
        RUN: begin
          if (tick) begin
            count_next = count_reg - WIDTH'(1);
            if (count_reg == WIDTH'(1)) begin
              state_next = EXPIRED;
              done_next  = 1'b1;
            end
          end
        end
        EXPIRED: begin
        end
        default: begin
          state_next = IDLE;
          count_next = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      done_reg  <= done_next;
    end
  end

  assign bus.count   = count_reg;
  assign bus.running = (state_reg == RUN);
  assign bus.expired = (state_reg == EXPIRED);
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_eight_bit_down_counter.sv
// Directed bench: a divide-by-1 and a divide-by-4 counter checked every cycle against a scoreboard.
module tb_eight_bit_down_counter;

  logic clock = 1'b0;
  logic reset = 1'b0;

  eight_bit_down_counter_if #(.WIDTH(8)) bus0 ();
  eight_bit_down_counter_if #(.WIDTH(8)) bus1 ();

  eight_bit_down_counter #(.WIDTH(8), .PRESCALE(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  eight_bit_down_counter #(.WIDTH(8), .PRESCALE(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  always #5 clock = ~clock;

  logic       ld [2];
  logic [7:0] lv [2];
  logic       en [2];

  assign bus0.load       = ld[0];
  assign bus0.load_value = lv[0];
  assign bus0.enable     = en[0];
  assign bus1.load       = ld[1];
  assign bus1.load_value = lv[1];
  assign bus1.enable     = en[1];

  typedef struct {
    int         d;
    logic [7:0] cnt;
    logic       run;
    logic       exp;
    logic       done;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;
  int psc [2] = '{1, 4};
  int m_cnt [2];
  int m_st [2];   // 0 idle, 1 run, 2 expired
  int m_pre [2];
  bit m_done [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cnt[d]  = 0;
      m_st[d]   = 0;
      m_pre[d]  = 0;
      m_done[d] = 1'b0;
    end
  endtask

  task automatic model_edge(input int d);
    if (ld[d]) begin
      m_cnt[d] = int'(lv[d]);
      m_pre[d] = 0;
      m_st[d]  = (lv[d] == 8'd0) ? 2 : 1;
      m_done[d] = (lv[d] == 8'd0);
    end else begin
      m_done[d] = 1'b0;
      if (m_st[d] == 1 && en[d]) begin
        if (m_pre[d] == psc[d] - 1) begin
          m_pre[d] = 0;
          m_cnt[d] = m_cnt[d] - 1;
          if (m_cnt[d] == 0) begin
            m_st[d]   = 2;
            m_done[d] = 1'b1;
          end
        end else begin
          m_pre[d] = m_pre[d] + 1;
        end
      end
    end
  endtask

  task automatic step(input string tag);
    exp_t e;
    logic [10:0] obs;
    for (int d = 0; d < 2; d++) begin
      model_edge(d);
      e.d    = d;
      e.cnt  = m_cnt[d][7:0];
      e.run  = (m_st[d] == 1);
      e.exp  = (m_st[d] == 2);
      e.done = m_done[d];
      sbq.push_back(e);
    end
    @(posedge clock);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      obs = (e.d == 0) ? {bus0.count, bus0.running, bus0.expired, bus0.done}
                       : {bus1.count, bus1.running, bus1.expired, bus1.done};
      chk($sformatf("%s.d%0d.count", tag, e.d), 32'(obs[10:3]), 32'(e.cnt));
      chk($sformatf("%s.d%0d.flags", tag, e.d), 32'(obs[2:0]), 32'({e.run, e.exp, e.done}));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".d0"}, 32'({bus0.count, bus0.running, bus0.expired, bus0.done}), 32'd0);
    chk({tag, ".d1"}, 32'({bus1.count, bus1.running, bus1.expired, bus1.done}), 32'd0);
  endtask

  initial begin
    int cyc;
    for (int d = 0; d < 2; d++) begin
      ld[d] = 1'b0;
      lv[d] = 8'd0;
      en[d] = 1'b0;
    end
    model_reset();

    // Asynchronous reset between edges
    #2 reset = 1'b1;
    #1 chk_zero("reset_async");
    #24 reset = 1'b0;

    // Enable without load leaves both counters idle
    en[0] = 1'b1;
    en[1] = 1'b1;
    repeat (3) step("idle_enable");
    chk("idle_running", 32'(bus0.running), 32'd0);

    // Basic countdown, divide-by-1
    ld[0] = 1'b1; lv[0] = 8'd5;
    step("basic_load");
    ld[0] = 1'b0;
    cyc = 0;
    while (cyc < 30 && !bus0.expired) begin
      step("basic_run");
      cyc++;
    end
    chk("basic_expiry_edge", 32'(cyc), 32'd5);
    repeat (20) step("basic_hold");

    // Divide-by-4 with a six-cycle pause
    ld[1] = 1'b1; lv[1] = 8'd3;
    step("psc_load");
    ld[1] = 1'b0;
    cyc = 0;
    while (cyc < 40 && !bus1.expired) begin
      if (cyc == 5)  en[1] = 1'b0;
      if (cyc == 11) en[1] = 1'b1;
      step("psc_run");
      cyc++;
    end
    chk("psc_expiry_edge", 32'(cyc), 32'd18);
    repeat (3) step("psc_hold");

    // Load of zero, then reload of zero while expired
    ld[0] = 1'b1; lv[0] = 8'd0;
    step("load0");
    chk("load0_done", 32'({bus0.expired, bus0.done}), 32'd3);
    ld[0] = 1'b0;
    repeat (2) step("load0_hold");
    ld[0] = 1'b1;
    step("reload0");
    chk("reload0_done", 32'(bus0.done), 32'd1);
    ld[0] = 1'b0;
    step("reload0_after");

    // Full-scale load: 255 decrements, no wrap
    ld[0] = 1'b1; lv[0] = 8'd255;
    step("max_load");
    ld[0] = 1'b0;
    cyc = 0;
    while (cyc < 300 && !bus0.expired) begin
      step("max_run");
      cyc++;
    end
    chk("max_expiry_edge", 32'(cyc), 32'd255);
    repeat (5) step("max_hold");

    // Load colliding with the final tick
    ld[0] = 1'b1; lv[0] = 8'd2;
    step("col_load");
    ld[0] = 1'b0;
    step("col_run");
    ld[0] = 1'b1; lv[0] = 8'd9;
    step("col_reload");
    chk("col_count", 32'({bus0.count, bus0.running, bus0.done}), 32'({8'd9, 1'b1, 1'b0}));
    ld[0] = 1'b0;
    cyc = 0;
    while (cyc < 30 && !bus0.expired) begin
      step("col_run2");
      cyc++;
    end
    chk("col_expiry_edge", 32'(cyc), 32'd9);
    ld[0] = 1'b1; lv[0] = 8'd3;
    step("exp_reload");
    ld[0] = 1'b0;
    cyc = 0;
    while (cyc < 30 && !bus0.expired) begin
      step("exp_run");
      cyc++;
    end
    chk("exp_reload_edge", 32'(cyc), 32'd3);

    // Reset in the middle of a count
    ld[0] = 1'b1; lv[0] = 8'd100;
    step("rst_load");
    ld[0] = 1'b0;
    cyc = 0;
    while (cyc < 100 && bus0.count != 8'd40) begin
      step("rst_run");
      cyc++;
    end
    chk("rst_reach40", 32'(cyc), 32'd60);
    #2 reset = 1'b1;
    #1 chk_zero("rst_midrun");
    model_reset();
    #3 reset = 1'b0;
    repeat (30) step("rst_after");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/eight_bit_down_counter.md
# eight_bit_down_counter

Loadable 8-bit down counter with prescaler and terminal-count detection, the countdown side of the reaction-time game. It loads a start value, such as the randomized pre-"go" delay, and decrements once per prescaled tick while enabled. At zero it stops, holds, flags expiry and emits a one-cycle Done pulse that the game controller uses to light the "go" indicator. It is the complement of the up counter that measures the player's response time.

## Interface
- WIDTH, 8: counter width in bits; all arithmetic is unsigned.
- PRESCALE, 1: Clock cycles per decrement while Enable is high; legal range 1..65535.
- Clock  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- Load  in  1  synchronous load strobe; priority over counting.
- LoadValue  in  WIDTH  start value, sampled when Load=1.
- Enable  in  1  count enable; low freezes both the count and the prescaler.
- Count  out  WIDTH  current count (registered).
- Running  out  1  high in state RUN.
- Expired  out  1  high in state EXPIRED (level).
- Done  out  1  one-cycle pulse on entry to EXPIRED.

## Operation
- FSM states:
  - IDLE: after reset; Count=0; ignores Enable.
  - RUN: counting.
  - EXPIRED: Count held at 0.
- Load=1, any state:
  - Count←LoadValue; prescaler←0.
  - Next state is RUN if LoadValue≠0, otherwise EXPIRED (Done pulses).
- RUN, Load=0, Enable=1:
  - Prescaler increments each cycle.
  - When prescaler==PRESCALE-1, prescaler←0 and Count←Count-1 (a "tick").
- RUN, Enable=0: Count and prescaler hold.
- RUN, tick with Count==1: Count←0 and state←EXPIRED on the same edge.
- EXPIRED: stays until Load or Reset; Enable has no effect. Count never wraps below 0.
- Load and tick in the same cycle: Load wins and the tick is discarded.
- Load=1 while already EXPIRED with LoadValue=0: re-enters EXPIRED and Done pulses again.
- Outputs are decoded from registered state only, with no combinational path from inputs:
  - Running = (state==RUN)
  - Expired = (state==EXPIRED)
  - Done is a register set on any edge that transitions into EXPIRED, including Load with LoadValue=0, and cleared otherwise.

## Timing
- Reset asserted (async): Count=0, state=IDLE, Running=0, Expired=0, Done=0, prescaler=0, all without waiting for an edge. Release is taken synchronously at the next edge.
- Reset mid-RUN aborts the count; no Done is produced.
- Load latency: Count=LoadValue is visible the cycle after the Load edge.
- Countdown timing, with Load of N≥1 at edge 0 and Enable held high:
  - Count changes every PRESCALE cycles.
  - Count reaches 0 and Expired rises after edge N·PRESCALE.
  - Done is high for exactly that one following cycle.
- Each cycle of Enable=0 during RUN extends the expiry by one cycle.
- Load with LoadValue=0 at edge k: Expired=1 and Done=1 in the cycle after edge k.
- Max count is 2^WIDTH-1 = 255.

## Structure
- Shared package holds:
  - the state enum (IDLE, RUN, EXPIRED), 2-bit encoding;
  - the default WIDTH constant, shared with the up counter.
- One sub-module, tick_prescaler:
  - parameter PRESCALE; ports Clock, Reset, Clear, Enable, Tick;
  - internal counter of width $clog2(PRESCALE) (minimum 1 bit);
  - Tick is combinational and high when Enable and count==PRESCALE-1;
  - PRESCALE=1 gives Tick=Enable.
- Top level holds the FSM, count register and output decode.

## Test plan
- Reset/idle: assert Reset mid-cycle with no edge → Count=0, Running/Expired/Done=0 immediately; after release, Enable=1 with no Load → stays IDLE, Count=0.
- Basic countdown: PRESCALE=1, Load 5, Enable=1 → Count 5,4,3,2,1,0 on successive cycles; Expired rises and Done pulses once, 5 cycles after the load edge; Count stays 0 for 20 more cycles.
- Prescale and pause: PRESCALE=4, Load 3, Enable low for 6 cycles mid-count → expiry at 12+6=18 cycles after load; Count values only change on tick edges.
- Load edge cases:
  - Load 0 → Expired=1 and Done=1 one cycle later, Running never high.
  - Load 255 → 255 decrements, no wrap.
- Collisions: Load 9 asserted on the same cycle Count would go 1→0 → Count=9, RUN, no Done; reload during EXPIRED restarts the count.
- Reset mid-run: Load 100, Reset at Count=40 → all outputs 0 asynchronously; no Done pulse afterward.
